cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0.sv | 104 ++++++++++
 tb/tb_cp0.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// CP0 coprocessor: SR/Cause/EPC/PRId registers, interrupt/exception request
// generation and exception-entry state capture.
module cp0 (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC_M,
   input  logic        BD_M,
   input  logic [4:0]  ExcCode_M,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] DOut,
   output logic [31:0] EPC_out,
   output logic        Req
);

   localparam int unsigned ADDR_W = 5;
   localparam logic [ADDR_W-1:0] A_SR    = ADDR_W'(12);
   localparam logic [ADDR_W-1:0] A_CAUSE = ADDR_W'(13);
   localparam logic [ADDR_W-1:0] A_EPC   = ADDR_W'(14);
   localparam logic [ADDR_W-1:0] A_PRID  = ADDR_W'(15);
   localparam logic [31:0]       PRID    = 32'h2022_1108;

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   // EPC is word aligned, so only [31:2] is stored
   logic [29:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_victim;
   logic [31:0] sr_val;
   logic [31:0] cause_val;
   logic [31:0] epc_val;
   logic        unused_bits;

   assign int_req    = ie & ~exl & (|(HWInt & im));
   assign exc_req    = ~exl & (ExcCode_M != 5'd0);
   assign Req        = ~reset & (int_req | exc_req);

   // A delay-slot victim restarts at its branch
   assign epc_victim = BD_M ? (PC_M - 32'd4) : PC_M;
   assign unused_bits = ^epc_victim[1:0];

   assign sr_val    = {16'd0, im, 8'd0, exl, ie};
   assign cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
   assign epc_val   = {epc, 2'b00};
   assign EPC_out   = epc_val;

   // mfc0 read mux
   always_comb begin
      DOut = 32'd0;
      case (A)
         A_SR:    DOut = sr_val;
         A_CAUSE: DOut = cause_val;
         A_EPC:   DOut = epc_val;
         A_PRID:  DOut = PRID;
         default: DOut = 32'd0;
      endcase
   end

   // Exception entry has priority over mtc0 and eret on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 30'd0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BD_M;
            exc_code <= int_req ? 5'd0 : ExcCode_M;
            epc      <= epc_victim[31:2];
         end else begin
            if (WE && (A == A_SR)) begin
               im  <= DIn[15:10];
               exl <= DIn[1];
               ie  <= DIn[0];
            end
            if (WE && (A == A_EPC)) begin
               epc <= DIn[31:2];
            end
            // eret clear overrides an SR write of EXL in the same cycle
            if (EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: register access, request generation,
// exception entry, eret and reset behaviour.
module tb_cp0;

   logic        clk;
   logic        reset;
   logic [4:0]  A;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC_M;
   logic        BD_M;
   logic [4:0]  ExcCode_M;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] DOut;
   logic [31:0] EPC_out;
   logic        Req;

   int n_cmp;
   int n_bad;

   cp0 dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .DIn       (DIn),
      .WE        (WE),
      .PC_M      (PC_M),
      .BD_M      (BD_M),
      .ExcCode_M (ExcCode_M),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .DOut      (DOut),
      .EPC_out   (EPC_out),
      .Req       (Req)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then changed 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input logic [4:0] a, input string tag, input logic [31:0] exp);
      A = a;
      #1;
      check_eq(tag, DOut, exp);
   endtask

   task automatic req_chk(input string tag, input logic exp);
      #1;
      check_eq(tag, {31'd0, Req}, {31'd0, exp});
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b1;
      A         = 5'd0;
      DIn       = 32'd0;
      WE        = 1'b0;
      PC_M      = 32'd0;
      BD_M      = 1'b0;
      ExcCode_M = 5'd0;
      HWInt     = 6'd0;
      EXLClr    = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Post-reset state
      read_chk(5'd12, "rst_sr", 32'h0);
      read_chk(5'd13, "rst_cause", 32'h0);
      read_chk(5'd14, "rst_epc", 32'h0);
      read_chk(5'd15, "prid", 32'h2022_1108);
      read_chk(5'd3, "unmapped_a", 32'h0);
      check_eq("rst_epc_out", EPC_out, 32'h0);
      req_chk("rst_req", 1'b0);

      // V1: enable interrupts, then HWInt[2] taken
      A = 5'd12; DIn = 32'h0000_FC01; WE = 1'b1; HWInt = 6'b000100; PC_M = 32'h3008;
      req_chk("v1_req_before_ie", 1'b0);
      tick();
      WE = 1'b0;
      req_chk("v1_req", 1'b1);
      read_chk(5'd12, "v1_sr_pre", 32'h0000_FC01);
      tick();
      HWInt = 6'd0;
      read_chk(5'd12, "v1_sr", 32'h0000_FC03);
      read_chk(5'd13, "v1_cause", 32'h0000_1000);
      read_chk(5'd14, "v1_epc", 32'h0000_3008);
      check_eq("v1_epc_out", EPC_out, 32'h0000_3008);

      // SR write together with eret: EXL ends at 0
      A = 5'd12; DIn = 32'h0000_FC02; WE = 1'b1; EXLClr = 1'b1;
      tick();
      WE = 1'b0; EXLClr = 1'b0;
      read_chk(5'd12, "sr_wr_eret", 32'h0000_FC00);

      // V2: RI exception in a delay slot with IE=0
      ExcCode_M = 5'd10; PC_M = 32'h3010; BD_M = 1'b1;
      req_chk("v2_req", 1'b1);
      tick();
      ExcCode_M = 5'd0; BD_M = 1'b0;
      read_chk(5'd13, "v2_cause", 32'h8000_0028);
      read_chk(5'd14, "v2_epc", 32'h0000_300C);
      read_chk(5'd12, "v2_sr", 32'h0000_FC02);

      // V3: EXL blocks requests; eret re-enables the pending interrupt
      ExcCode_M = 5'd4; HWInt = 6'h3F; PC_M = 32'h3020;
      A = 5'd12; DIn = 32'h0000_FC03; WE = 1'b1;
      req_chk("v3_req_exl_a", 1'b0);
      tick();
      WE = 1'b0;
      req_chk("v3_req_exl_b", 1'b0);
      tick();
      check_eq("v3_epc_hold", EPC_out, 32'h0000_300C);
      ExcCode_M = 5'd0; EXLClr = 1'b1;
      req_chk("v3_req_eret_cycle", 1'b0);
      tick();
      EXLClr = 1'b0; PC_M = 32'h3030;
      read_chk(5'd12, "v3_sr_after_eret", 32'h0000_FC01);
      req_chk("v3_req_reassert", 1'b1);
      tick();
      HWInt = 6'd0;
      read_chk(5'd13, "v3_cause", 32'h0000_FC00);
      read_chk(5'd14, "v3_epc", 32'h0000_3030);

      // V4: exception discards a same-cycle EPC write
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      ExcCode_M = 5'd12; PC_M = 32'h3020; A = 5'd14; DIn = 32'hDEAD_BEEF; WE = 1'b1;
      req_chk("v4_req", 1'b1);
      tick();
      WE = 1'b0; ExcCode_M = 5'd0;
      read_chk(5'd14, "v4_epc", 32'h0000_3020);
      read_chk(5'd13, "v4_cause", 32'h0000_0030);
      read_chk(5'd12, "v4_sr", 32'h0000_FC03);

      // mtc0 EPC aligns; writes to PRId are ignored
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      A = 5'd14; DIn = 32'h1234_5677; WE = 1'b1;
      tick();
      A = 5'd15; DIn = 32'h0;
      tick();
      WE = 1'b0;
      check_eq("mtc0_epc", EPC_out, 32'h1234_5674);
      read_chk(5'd15, "prid_wr_ignored", 32'h2022_1108);

      // V5: interrupt beats a simultaneous exception
      HWInt = 6'd1; ExcCode_M = 5'd4; PC_M = 32'h3040;
      req_chk("v5_req", 1'b1);
      tick();
      HWInt = 6'd0; ExcCode_M = 5'd0;
      read_chk(5'd13, "v5_cause", 32'h0000_0400);
      read_chk(5'd14, "v5_epc", 32'h0000_3040);

      // V6: reset during a request cycle, then Cause write is ignored
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      HWInt = 6'd1;
      req_chk("v6_req_pre", 1'b1);
      reset = 1'b1; A = 5'd14; DIn = 32'hFFFF_FFFF; WE = 1'b1;
      req_chk("v6_req_in_reset", 1'b0);
      tick();
      reset = 1'b0; WE = 1'b0; HWInt = 6'd0;
      read_chk(5'd12, "v6_sr", 32'h0);
      read_chk(5'd13, "v6_cause", 32'h0);
      read_chk(5'd14, "v6_epc", 32'h0);
      check_eq("v6_epc_out", EPC_out, 32'h0);
      req_chk("v6_req", 1'b0);
      HWInt = 6'b101010; A = 5'd13; DIn = 32'hFFFF_FFFF; WE = 1'b1;
      tick();
      WE = 1'b0;
      read_chk(5'd13, "v6_cause_wr", 32'h0000_A800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
